// File: rtl/dwt_decimator_pkg.sv
// dwt_pkg: shared sample widths, saturation limits and the 20-to-16-bit clamp
package dwt_pkg;
    localparam int FILT_W = 20;
    localparam int SAMP_W = 16;
    localparam logic signed [SAMP_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMP_W-1:0] SAT_MIN = 16'sh8000;
    function automatic logic signed [SAMP_W-1:0] sat16(input logic signed [FILT_W-1:0] x);
        return (x > SAT_MAX) ? SAT_MAX : (x < SAT_MIN) ? SAT_MIN : x[SAMP_W-1:0];
    endfunction
endpackage

// File: rtl/dwt_decimator_sync_fifo.sv
// sync_fifo: circular buffer with occupancy count; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;
    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) mem[wptr] <= wdata;
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/dwt_decimator.sv
// dwt_decimator: keep one filter sample in two, scale and saturate to 16 bits, buffer in a FIFO
module dwt_decimator
    import dwt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PHASE = 0,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [FILT_W-1:0] data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [SAMP_W-1:0] data_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    logic                     ph, keep, st_valid, pop, full, empty;
    logic signed [SAMP_W-1:0] st_data;
    logic signed [FILT_W-1:0] scaled;
    logic [SAMP_W-1:0]        head;
    assign keep      = in_valid && (ph == 1'(PHASE));
    assign scaled    = data_in >>> SHIFT;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign data_out  = head;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 1'b0;
            st_valid <= 1'b0;
            st_data  <= '0;
            overflow <= 1'b0;
        end else begin
            ph       <= ph ^ in_valid;
            st_valid <= keep;
            if (keep) st_data <= sat16(scaled);
            // a drop in the same cycle wins over a clear request
            if (st_valid && full && !pop) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end
    sync_fifo #(.WIDTH(SAMP_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (st_valid),
        .pop   (pop),
        .wdata (st_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule

// File: tb/tb_dwt_decimator.sv
// tb_dwt_decimator: two decimator instances (even phase/no shift, odd phase/shift 2) against a queue model
module tb_dwt_decimator;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
    logic signed [19:0] data_in = '0;
    logic [1:0] ov, ovf;
    logic [3:0] lv [2];
    logic signed [15:0] dout [2];
    int vectors = 0, miscompares = 0;
    int mq [2][$];
    int m_ph [2], m_stv [2], m_std [2], m_ovf [2];
    always #5 clk = ~clk;
    dwt_decimator #(.DEPTH(8), .PHASE(0), .SHIFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in), .out_valid(ov[0]),
        .out_ready(out_ready), .data_out(dout[0]), .level(lv[0]), .overflow(ovf[0]), .clr_ovf(clr_ovf)
    );
    dwt_decimator #(.DEPTH(8), .PHASE(1), .SHIFT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in), .out_valid(ov[1]),
        .out_ready(out_ready), .data_out(dout[1]), .level(lv[1]), .overflow(ovf[1]), .clr_ovf(clr_ovf)
    );
    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int ref_sample(input int x, input int sh);
        int s;
        s = x >>> sh;
        return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_ph[i] = 0; m_stv[i] = 0; m_std[i] = 0; m_ovf[i] = 0;
        end
    endtask
    task automatic model_edge();
        bit pop;
        bit dropped;
        for (int i = 0; i < 2; i++) begin
            pop = mq[i].size() != 0 && out_ready;
            dropped = 0;
            if (pop) void'(mq[i].pop_front());
            if (m_stv[i] != 0) begin
                if (mq[i].size() < 8) mq[i].push_back(m_std[i]);
                else dropped = 1;
            end
            if (dropped) m_ovf[i] = 1;
            else if (clr_ovf) m_ovf[i] = 0;
            m_stv[i] = (in_valid && m_ph[i] == i) ? 1 : 0;
            if (m_stv[i] != 0) m_std[i] = ref_sample(int'(data_in), i == 0 ? 0 : 2);
            if (in_valid) m_ph[i] ^= 1;
        end
    endtask
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("out_valid%0d", i), int'(ov[i]), mq[i].size() != 0 ? 1 : 0);
            check($sformatf("level%0d", i), int'(lv[i]), mq[i].size());
            check($sformatf("overflow%0d", i), int'(ovf[i]), m_ovf[i]);
            if (mq[i].size() != 0) check($sformatf("data_out%0d", i), int'(dout[i]), mq[i][0]);
        end
    endtask
    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_out_valid%0d", tag, i), int'(ov[i]), 0);
            check($sformatf("%s_level%0d", tag, i), int'(lv[i]), 0);
            check($sformatf("%s_overflow%0d", tag, i), int'(ovf[i]), 0);
            check($sformatf("%s_data_out%0d", tag, i), int'(dout[i]), 0);
        end
    endtask
    task automatic cycle(input bit v, input int d, input bit rdy, input bit clr);
        in_valid = v; data_in = 20'(d); out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        #1 check_all();
    endtask
    function automatic int rnd_data();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1048575)) - 524288;
        return int'($urandom_range(0, 80000)) - 40000;
    endfunction
    initial begin
        int sat_seq [7];
        sat_seq = '{0, 40000, 100000, -40000, 100000, 32767, 100000};
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset("rst");
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) cycle(1, k, 1, 0);
        repeat (4) cycle(0, 0, 1, 0);
        cycle(1, 10, 1, 0); cycle(0, 0, 1, 0); cycle(0, 0, 1, 0); cycle(1, 20, 1, 0); cycle(1, 30, 1, 0);
        repeat (3) cycle(0, 0, 1, 0);
        for (int k = 0; k < 7; k++) cycle(1, sat_seq[k], 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        repeat (6) cycle(0, 0, 1, 0);
        repeat (40) cycle(1, rnd_data(), 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        repeat (12) cycle(0, 0, 1, 0);
        repeat (17) cycle(1, rnd_data(), 0, 0);
        cycle(1, rnd_data(), 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        repeat (12) cycle(0, 0, 1, 0);
        repeat (10) cycle(1, rnd_data(), 0, 0);
        cycle(0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1 check_reset("midrst");
        @(negedge clk); rst_n = 1'b1;
        repeat (6) cycle(1, rnd_data(), 1, 0);
        repeat (3) cycle(0, 0, 1, 0);
        repeat (3000) cycle($urandom_range(0, 9) < 7, rnd_data(), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        repeat (12) cycle(0, 0, 1, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dwt_decimator.md
# dwt_decimator

Downsample-by-2 and output buffer stage directly downstream of the 4-tap wavelet FIR `filter`. Takes the filter's 20-bit signed output and keeps one sample in two, as the DWT decimation requires. Each kept sample is arithmetically scaled and saturated to 16 bits, then buffered in a small FIFO. The FIFO presents the samples to the next wavelet level or to memory over a valid/ready handshake.

## Interface
- `DEPTH`, 8: FIFO depth in samples; power of two, 2..64.
- `PHASE`, 0: which input of each pair is kept (0 = even-indexed, 1 = odd-indexed).
- `SHIFT`, 0: arithmetic right shift applied before saturation, 0..4.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `data_in` carries a filter sample this cycle.
- `data_in`  in  20 signed  filter output.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head this cycle.
- `data_out`  out  16 signed  FIFO head sample.
- `level`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: a kept sample was dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Phase bit `ph`:
  - resets to 0;
  - toggles on every `in_valid` cycle;
  - holds when `in_valid`=0.
- Sample kept when `in_valid && ph==PHASE`; otherwise discarded.
- Scale: `s = data_in >>> SHIFT`, sign-preserving.
- Saturate: clamp `s` to [-32768, 32767]; values in range pass unchanged.
- The kept, saturated sample goes into the stage register `st_data` with `st_valid`=1. `st_valid` clears on the next cycle if no new keep.
- FIFO push occurs when `st_valid`=1:
  - not full: write at the write pointer, pointer increments.
  - full and a pop in the same cycle: write accepted; `level` unchanged.
  - full and no pop: sample dropped; `overflow` set to 1.
- FIFO pop occurs when `out_valid && out_ready`; `out_ready` while empty is ignored.
- Pointers wrap modulo DEPTH.
- `level` changes per cycle by +1 on push only, −1 on pop only, 0 on both or neither.
- `out_valid` = (`level` != 0); `data_out` = entry at the read pointer. Both come from registers, not combinationally from the input.
- `overflow`:
  - set has priority over `clr_ovf` in the same cycle;
  - otherwise `clr_ovf` clears it.
- No state machine beyond the phase bit. Pipeline: input → stage register → FIFO.

## Timing
- Reset values:
  - `out_valid`=0, `data_out`=0, `level`=0, `overflow`=0;
  - `ph`=0, `st_valid`=0, pointers 0.
- Asserting `rst_n` mid-operation empties the FIFO and loses in-flight samples. Phase restarts at 0.
- Latency: sample kept at edge N → `st_valid` after N → FIFO write at N+1 → `out_valid`=1 in the cycle after edge N+1 (2 cycles) when the FIFO was empty.
- Throughput: at most one kept sample per 2 `in_valid` cycles. A consumer with `out_ready` held high therefore never overflows the FIFO.
- `data_out` must be stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `dwt_pkg`:
  - `FILT_W`=20, `SAMP_W`=16;
  - `SAT_MAX`=16'sh7FFF, `SAT_MIN`=16'sh8000;
  - a function `sat16(input signed [19:0])`.
- Sub-module `sync_fifo`: parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty, level; same clock and reset.
- Top module holds the phase bit, the shift/saturate logic, the stage register and the overflow flag.

## Test plan
- Decimation: PHASE=0, SHIFT=0, `out_ready`=1, `in_valid`=1 continuous, data 1,2,3,4,5,6 → `data_out` sequence 1,3,5, first `out_valid` 2 cycles after the sample 1 edge. With PHASE=1 → 2,4,6.
- Gapped input: `in_valid` pattern 1,0,0,1,1 with data 10,x,x,20,30 → kept samples 10 and 30. The phase bit must not advance on idle cycles.
- Saturation, SHIFT=0: inputs 20'sd40000, -20'sd40000, 20'sd32767 → outputs 32767, -32768, 32767. With SHIFT=2 and input 20'sd100000 → 25000.
- Backpressure/overflow: DEPTH=8, `out_ready`=0, 20 kept samples. `level` saturates at 8, `overflow` goes to 1, and after release `data_out` yields the first 8 samples in order.
  - `clr_ovf` pulse → `overflow` returns to 0.
- Full with simultaneous push and pop: fill the FIFO to 8, then `out_ready`=1 in the same cycle as a push. `level` stays 8, no overflow, the new sample appears at the tail.
- Reset mid-stream: FIFO at `level`=5, pulse `rst_n` low for 1 cycle → `level`=0, `out_valid`=0 immediately. Next kept sample follows PHASE=0 parity from reset.
